// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes, the payload
// control bundle and the mapping from shift level to pipeline stage.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    // Control fields that travel with every beat; the data, cnt and tag
    // fields depend on module parameters and are wrapped around this in the top.
    typedef struct packed {
        op_e  op;
        logic sign;
        logic valid;
    } payload_ctrl_t;

    function automatic int stage_of(int lvl, int stages, int levels);
        return (lvl * stages) / levels;
    endfunction

    function automatic int first_level(int stage, int stages, int levels);
        for (int i = 0; i < levels; i++)
            if (stage_of(i, stages, levels) == stage) return i;
        return 0;
    endfunction

    function automatic int last_level(int stage, int stages, int levels);
        for (int i = levels - 1; i >= 0; i--)
            if (stage_of(i, stages, levels) == stage) return i;
        return 0;
    endfunction

endpackage

// File: rtl/shift_if.sv
// Valid/ready request and response bundle of the shifter; the shifter
// consumes requests and produces results through the slave modport.
interface shift_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );

endinterface

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: moves data by 2**LVL
// positions in the direction selected by op when en is set.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LVL   = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  op_e              op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);
    localparam int SH = 2 ** LVL;

    logic [WIDTH-1:0] moved;

    // NOTE: assign a default before the case so every path drives moved and no latch is inferred.
    always_comb begin
        moved = data;
        case (op)
            OP_ROL:  moved = {data[WIDTH-1-SH:0], data[WIDTH-1 -: SH]};
            OP_SLL:  moved = data << SH;
            OP_SRL:  moved = data >> SH;
            OP_SRA:  moved = {{SH{sign}}, data[WIDTH-1:SH]};
            default: moved = data;
        endcase
    end

    assign result = en ? moved : data;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides; the shift
// levels are spread over STAGES register stages under a global stall.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic    clk,
    input logic    rst,
    shift_if.slave bus
);
    localparam int LVLS = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LVLS-1:0]  cnt;
        logic [TAG_W-1:0] tag;
        payload_ctrl_t    ctrl;
    } payload_t;

    payload_t         pl_in   [STAGES];
    payload_t         stage_d [STAGES];
    payload_t         stage_q [STAGES];
    logic [WIDTH-1:0] lvl_out [LVLS];
    logic             advance;
    logic             zero_q;

    assign advance      = !stage_q[STAGES-1].ctrl.valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Idle input fields are forced to zero so don't-care operands never enter the pipe.
    always_comb begin
        pl_in[0]           = '0;
        pl_in[0].ctrl.valid = bus.in_valid;
        if (bus.in_valid) begin
            pl_in[0].data      = bus.in_data;
            pl_in[0].cnt       = bus.in_cnt;
            pl_in[0].tag       = bus.in_tag;
            pl_in[0].ctrl.op   = op_e'(bus.in_op);
            pl_in[0].ctrl.sign = bus.in_data[WIDTH-1];
        end
        for (int s = 1; s < STAGES; s++)
            pl_in[s] = stage_q[s-1];
    end

    for (genvar i = 0; i < LVLS; i++) begin : g_lvl
        localparam int S = stage_of(i, STAGES, LVLS);
        logic [WIDTH-1:0] src;

        if (i == first_level(S, STAGES, LVLS)) begin : g_head
            assign src = pl_in[S].data;
        end else begin : g_chain
            assign src = lvl_out[i-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .LVL   (i)
        ) u_level (
            .data   (src),
            .en     (pl_in[S].cnt[i]),
            .op     (pl_in[S].ctrl.op),
            .sign   (pl_in[S].ctrl.sign),
            .result (lvl_out[i])
        );
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s]      = pl_in[s];
            stage_d[s].data = lvl_out[last_level(s, STAGES, LVLS)];
        end
    end

    // NOTE: state updates use <= so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the pipeline is plain flops, so it is fully cleared; in-flight beats are dropped.
            for (int s = 0; s < STAGES; s++)
                stage_q[s] <= '0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++)
                stage_q[s] <= stage_d[s];
            zero_q <= stage_d[STAGES-1].ctrl.valid && (stage_d[STAGES-1].data == '0);
        end
    end

    assign bus.out_valid = stage_q[STAGES-1].ctrl.valid;
    assign bus.out_data  = stage_q[STAGES-1].data;
    assign bus.out_tag   = stage_q[STAGES-1].tag;
    assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomized bench for shift_pipe: directed steps on a 16-bit,
// 2-stage instance, then a randomized sweep over several parameter sets.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int TAG_W = 4;
    localparam int NCFG  = 5;
    localparam int NBEAT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   go  = 1'b0;
    bit   done [NCFG];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    function automatic int cfg_w(int k);
        case (k)
            0: return 16;
            1: return 8;
            2: return 16;
            3: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_s(int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 4;
            3: return 5;
            default: return 3;
        endcase
    endfunction

    // Reference: whole-word arithmetic on a w-bit operand held in 64 bits.
    function automatic logic [63:0] ref_shift(int w, logic [1:0] op, logic [63:0] d, int n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d & mask;
        case (op)
            2'b00:   r = ((d << n) | (d >> (w - n))) & mask;
            2'b01:   r = (d << n) & mask;
            2'b10:   r = d >> n;
            default: begin
                r = d >> n;
                if (d[w-1]) r = r | (mask & ~(mask >> n));
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    shift_if #(.WIDTH(16), .TAG_W(TAG_W)) m_bus ();

    shift_pipe #(.WIDTH(16), .STAGES(2), .TAG_W(TAG_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_bus)
    );

    task automatic drive(input logic v, input op_e op, input logic [15:0] d,
                         input logic [3:0] c, input logic [3:0] t);
        m_bus.in_valid = v;
        m_bus.in_op    = op;
        m_bus.in_data  = d;
        m_bus.in_cnt   = c;
        m_bus.in_tag   = t;
    endtask

    task automatic vec(input string name, input op_e op, input logic [15:0] d,
                       input logic [3:0] c, input logic [15:0] exp, input logic exp_zero);
        @(posedge clk); #1;
        drive(1'b1, op, d, c, 4'd9);
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check({name, "_valid"}, m_bus.out_valid, 1'b1);
        check({name, "_data"}, m_bus.out_data, exp);
        check({name, "_zero"}, m_bus.out_zero, exp_zero);
    endtask

    initial begin
        int  seen;
        int  t;
        bit  all_done;

        drive(1'b0, OP_ROL, 16'h0, 4'h0, 4'h0);
        m_bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", m_bus.out_valid, 1'b0);
        check("rst_out_data", m_bus.out_data, 16'h0);
        check("rst_out_tag", m_bus.out_tag, 4'h0);
        check("rst_out_zero", m_bus.out_zero, 1'b0);
        check("rst_in_ready", m_bus.in_ready, 1'b1);

        // Basic rotate with two-cycle latency.
        @(posedge clk); #1;
        m_bus.out_ready = 1'b1;
        drive(1'b1, OP_ROL, 16'h8001, 4'd1, 4'd3);
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        check("t1_not_yet", m_bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check("t1_valid", m_bus.out_valid, 1'b1);
        check("t1_data", m_bus.out_data, 16'h0003);
        check("t1_tag", m_bus.out_tag, 4'd3);

        vec("sra15", OP_SRA, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        vec("srl15", OP_SRL, 16'h8000, 4'd15, 16'h0001, 1'b0);
        vec("rol15", OP_ROL, 16'h8000, 4'd15, 16'h4000, 1'b0);
        vec("sll15", OP_SLL, 16'h0001, 4'd15, 16'h8000, 1'b0);
        vec("zero_rol", OP_ROL, 16'h0000, 4'd0, 16'h0000, 1'b1);
        vec("zero_sll", OP_SLL, 16'h0000, 4'd0, 16'h0000, 1'b1);
        vec("zero_srl", OP_SRL, 16'h0000, 4'd0, 16'h0000, 1'b1);
        vec("zero_sra", OP_SRA, 16'h0000, 4'd0, 16'h0000, 1'b1);
        vec("pass_sra", OP_SRA, 16'hA5C3, 4'd0, 16'hA5C3, 1'b0);
        repeat (3) @(posedge clk);

        // Backpressure: three beats against a stalled sink.
        #1;
        m_bus.out_ready = 1'b0;
        drive(1'b1, OP_SLL, 16'h0F0F, 4'd4, 4'd1);
        @(posedge clk); #1;
        drive(1'b1, OP_SRL, 16'hF000, 4'd12, 4'd2);
        @(posedge clk); #1;
        drive(1'b1, OP_SRA, 16'h8F00, 4'd8, 4'd3);
        #1;
        check("bp_in_ready_low", m_bus.in_ready, 1'b0);
        check("bp_head_valid", m_bus.out_valid, 1'b1);
        check("bp_head_tag", m_bus.out_tag, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_tag", m_bus.out_tag, 4'd1);
            check("bp_hold_data", m_bus.out_data, 16'hF0F0);
            check("bp_hold_valid", m_bus.out_valid, 1'b1);
        end
        m_bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", m_bus.in_ready, 1'b1);
        @(posedge clk); #1;
        m_bus.in_valid = 1'b0;
        check("bp_drain2_tag", m_bus.out_tag, 4'd2);
        check("bp_drain2_data", m_bus.out_data, 16'h000F);
        @(posedge clk); #1;
        check("bp_drain3_tag", m_bus.out_tag, 4'd3);
        check("bp_drain3_data", m_bus.out_data, 16'hFF8F);
        check("bp_drain3_valid", m_bus.out_valid, 1'b1);
        @(posedge clk); #1;
        check("bp_empty", m_bus.out_valid, 1'b0);

        // Reset with two beats in flight and a third offered during reset.
        drive(1'b1, OP_ROL, 16'h1234, 4'd4, 4'd5);
        @(posedge clk); #1;
        drive(1'b1, OP_SLL, 16'h00FF, 4'd2, 4'd6);
        @(posedge clk); #1;
        check("rst_mid_full", m_bus.out_valid, 1'b1);
        rst = 1'b1;
        drive(1'b1, OP_SRL, 16'hFFFF, 4'd1, 4'd7);
        @(posedge clk); #1;
        rst = 1'b0;
        m_bus.in_valid = 1'b0;
        check("rst_mid_valid", m_bus.out_valid, 1'b0);
        check("rst_mid_data", m_bus.out_data, 16'h0);
        check("rst_mid_in_ready", m_bus.in_ready, 1'b1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_emerge", seen, 0);

        go = 1'b1;
        all_done = 1'b0;
        for (t = 0; t < 20000 && !all_done; t++) begin
            @(posedge clk);
            all_done = 1'b1;
            for (int k = 0; k < NCFG; k++)
                if (!done[k]) all_done = 1'b0;
        end
        check("sweep_finished", all_done, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int W  = cfg_w(k);
        localparam int S  = cfg_s(k);
        localparam int CW = $clog2(W);

        typedef struct {
            logic [63:0]      data;
            logic [TAG_W-1:0] tag;
        } exp_t;

        shift_if #(.WIDTH(W), .TAG_W(TAG_W)) bus ();

        shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TAG_W)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        initial begin
            exp_t        q[$];
            exp_t        e;
            logic [63:0] r;
            logic [63:0] first_exp;
            int          lat, sent, got, dup, bad_tp, cyc;
            bit          hold, in_fire, out_fire;

            bus.in_valid  = 1'b0;
            bus.in_data   = '0;
            bus.in_cnt    = '0;
            bus.in_op     = 2'b00;
            bus.in_tag    = '0;
            bus.out_ready = 1'b0;
            done[k]       = 1'b0;
            wait (go);
            @(posedge clk); #1;

            // Unstalled latency of a single beat.
            r = {$urandom(), $urandom()};
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = r[W-1:0];
            bus.in_cnt    = CW'(W - 1);
            bus.in_op     = 2'b11;
            bus.in_tag    = 4'd10;
            first_exp     = ref_shift(W, 2'b11, r, W - 1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("w%0d_s%0d_latency", W, S), lat, S);
            check($sformatf("w%0d_s%0d_lat_data", W, S), bus.out_data, first_exp);
            @(posedge clk); #1;

            sent = 0; got = 0; dup = 0; bad_tp = 0; cyc = 0; hold = 1'b0;
            while (got < NBEAT && cyc < 6000) begin
                if (!hold) begin
                    if (sent < NBEAT) begin
                        r = {$urandom(), $urandom()};
                        bus.in_valid = 1'b1;
                        bus.in_data  = r[W-1:0];
                        bus.in_cnt   = CW'($urandom_range(0, W - 1));
                        bus.in_op    = 2'($urandom_range(0, 3));
                        bus.in_tag   = TAG_W'(sent);
                    end else begin
                        bus.in_valid = 1'b0;
                    end
                end
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                in_fire  = bus.in_valid && bus.in_ready;
                out_fire = bus.out_valid && bus.out_ready;
                if (bus.out_ready && !bus.in_ready) bad_tp++;
                if (out_fire) begin
                    if (q.size() == 0) begin
                        dup++;
                    end else begin
                        e = q.pop_front();
                        check($sformatf("w%0d_s%0d_data", W, S), bus.out_data, e.data);
                        check($sformatf("w%0d_s%0d_tag", W, S), bus.out_tag, e.tag);
                        check($sformatf("w%0d_s%0d_zero", W, S), bus.out_zero, e.data == 64'd0);
                    end
                    got++;
                end
                if (in_fire) begin
                    e.data = ref_shift(W, bus.in_op, 64'(bus.in_data), int'(bus.in_cnt));
                    e.tag  = bus.in_tag;
                    q.push_back(e);
                    sent++;
                end
                hold = bus.in_valid && !in_fire;
                @(posedge clk); #1;
                cyc++;
            end
            bus.in_valid = 1'b0;
            check($sformatf("w%0d_s%0d_beats_out", W, S), got, NBEAT);
            check($sformatf("w%0d_s%0d_leftover", W, S), q.size(), 0);
            check($sformatf("w%0d_s%0d_extra", W, S), dup, 0);
            check($sformatf("w%0d_s%0d_throughput", W, S), bad_tp, 0);
            done[k] = 1'b1;
        end
    end

endmodule
